matrix_mem_stream: RTL

//  Shared operand memory for the matrix PE array. One host write port, one host read port, an

---
 rtl/matrix_mem_stream.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/matrix_mem_stream.sv
// Shared operand memory: host write/read ports, zero-fill sequencer, NUM_CH strided burst read channels.
// Latency: host read 1 cycle; channel start at E0 -> first word valid after E1, then 1 word/cycle.
// Backpressure: per-channel valid/ready; a stalled channel holds data/last stable and issues no read.
//
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   w_en/w_addr/w_data            host write (dropped while clr_busy)
//   r_en/r_addr -> r_data/r_valid host registered read
//   clr_start -> clr_busy         zero-fill of the whole array, DEPTH cycles
//   ch_start/ch_base/ch_stride/ch_len   per-channel burst command, packed per channel
//   ch_data/ch_valid/ch_ready/ch_last   per-channel stream, packed per channel
//   ch_busy                       channel is in RUN
module matrix_mem_stream #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int WORD_W = 16,
  parameter int NUM_CH = 64,
  parameter int LEN_W  = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_en,
  input  logic [ADDR_W-1:0]          w_addr,
  input  logic [WORD_W-1:0]          w_data,
  input  logic                       r_en,
  input  logic [ADDR_W-1:0]          r_addr,
  output logic [WORD_W-1:0]          r_data,
  output logic                       r_valid,
  input  logic                       clr_start,
  output logic                       clr_busy,
  input  logic [NUM_CH-1:0]          ch_start,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_base,
  input  logic [ADDR_W*NUM_CH-1:0]   ch_stride,
  input  logic [LEN_W*NUM_CH-1:0]    ch_len,
  output logic [WORD_W*NUM_CH-1:0]   ch_data,
  output logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH-1:0]          ch_ready,
  output logic [NUM_CH-1:0]          ch_last,
  output logic [NUM_CH-1:0]          ch_busy
);

  localparam logic [0:0] CLR_IDLE = 1'b0;
  localparam logic [0:0] CLR_RUN  = 1'b1;
  localparam logic [0:0] CH_IDLE  = 1'b0;
  localparam logic [0:0] CH_RUN   = 1'b1;

  // Array has no reset: contents survive rst_n.
  logic [WORD_W-1:0] mem [DEPTH];

  logic [0:0]        clr_state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_go;

  assign clr_busy = (clr_state == CLR_RUN);
  assign clr_go   = clr_start && (clr_state == CLR_IDLE) && !(|ch_busy);

  // Zero-fill sequencer: one address per cycle, 0..DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_state <= CLR_IDLE;
      clr_cnt   <= '0;
    end else begin
      case (clr_state)
        CLR_IDLE: begin
          if (clr_go) begin
            clr_state <= CLR_RUN;
            clr_cnt   <= '0;
          end
        end
        default: begin
          clr_cnt <= clr_cnt + ADDR_W'(1);
          if (clr_cnt == {ADDR_W{1'b1}}) clr_state <= CLR_IDLE;
        end
      endcase
    end
  end

  // Single write port shared by the clear sequencer and the host; host
  // writes are discarded while clearing. All reads elsewhere are
  // non-blocking registered reads, so a same-edge collision returns old data.
  always_ff @(posedge clk) begin
    if (clr_busy) begin
      mem[clr_cnt] <= '0;
    end else if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_en;
      if (r_en) r_data <= mem[r_addr];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [0:0]        st;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] stride_q;
    logic [LEN_W-1:0]  rem_q;
    logic              vld_q;
    logic              last_q;
    logic [WORD_W-1:0] dat_q;
    logic              hs;
    logic              issue;
    logic              start_ok;

    assign hs       = vld_q && ch_ready[i];
    // Issue when the output register is empty or being drained this cycle.
    assign issue    = (st == CH_RUN) && (rem_q != '0) && (!vld_q || ch_ready[i]);
    assign start_ok = (st == CH_IDLE) && ch_start[i] && !clr_busy &&
                      (ch_len[i*LEN_W +: LEN_W] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st       <= CH_IDLE;
        addr_q   <= '0;
        stride_q <= '0;
        rem_q    <= '0;
        vld_q    <= 1'b0;
        last_q   <= 1'b0;
        dat_q    <= '0;
      end else begin
        case (st)
          CH_IDLE: begin
            if (start_ok) begin
              st       <= CH_RUN;
              addr_q   <= ch_base[i*ADDR_W +: ADDR_W];
              stride_q <= ch_stride[i*ADDR_W +: ADDR_W];
              rem_q    <= ch_len[i*LEN_W +: LEN_W];
            end
          end
          default: begin
            // last_q implies rem_q==0, so no new issue competes with this exit.
            if (hs && last_q) st <= CH_IDLE;
          end
        endcase

        if (issue) begin
          dat_q  <= mem[addr_q];
          vld_q  <= 1'b1;
          addr_q <= addr_q + stride_q;  // wraps modulo 2**ADDR_W
          rem_q  <= rem_q - LEN_W'(1);
          last_q <= (rem_q == LEN_W'(1));
        end else if (hs) begin
          vld_q  <= 1'b0;
          last_q <= 1'b0;
        end
      end
    end

    assign ch_data[i*WORD_W +: WORD_W] = dat_q;
    assign ch_valid[i]                 = vld_q;
    assign ch_last[i]                  = last_q;
    assign ch_busy[i]                  = (st == CH_RUN);
  end

endmodule
